laser_xy_tracker: RTL
=====================

LASER_XY_TRACKER -- requirements
Module: laser_xy_tracker

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 2, log2 of averaging window depth (window = 4 frames).
REQ-002 SHALL have parameter MAX_JUMP, default 64, max per-axis pixel distance for a sample to be accepted while tracking.
REQ-003 SHALL have parameter LOST_FRAMES, default 8, consecutive missed frames before the track is dropped.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port frame_end  input  1  one-cycle pulse marking end of frame; laser_xy and laser_found sampled on this cycle.
REQ-007 SHALL have port laser_found  input  1  upstream detector found a red run this frame.
REQ-008 SHALL have port laser_xy  input  32  {x[31:16], y[15:0]} from upstream laser detector.
REQ-009 SHALL have port out_xy  output  32  {x[31:16], y[15:0]} smoothed laser position.
REQ-010 SHALL have port out_valid  output  1  out_xy holds an unconsumed result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_xy when high with out_valid.
REQ-012 SHALL have port tracking  output  1  high in TRACK and COAST states.

Function
REQ-013 SHALL implement states ACQUIRE, TRACK, COAST; reset state ACQUIRE.
REQ-014 SHALL keep per-axis windows of 2^AVG_LOG2 16-bit samples and per-axis running sums of 16+AVG_LOG2 bits, unsigned, no overflow possible.
REQ-015 SHALL ignore laser_found and laser_xy on cycles where frame_end is low.
REQ-016 SHALL classify a frame_end sample as a hit if laser_found=1 and (state=ACQUIRE, or |x-out_x|<=MAX_JUMP and |y-out_y|<=MAX_JUMP); otherwise a miss.
REQ-017 SHALL, on a hit, push the sample into the window, drop the oldest when full, and update sum = sum + new - oldest.
REQ-018 ACQUIRE: hits increment fill count; on the hit that fills the window SHALL go to TRACK; a miss SHALL clear fill count and sums.
REQ-019 TRACK: hit stays TRACK; miss SHALL go to COAST with miss count = 1.
REQ-020 COAST: hit SHALL return to TRACK and clear miss count; miss SHALL increment miss count; on reaching LOST_FRAMES SHALL go to ACQUIRE, clearing window, sums, fill and miss counts.
REQ-021 SHALL produce a result only for hits that leave the state in TRACK; result = per-axis sum >> AVG_LOG2 (truncating).
REQ-022 SHALL register results so out_xy and out_valid update exactly 2 clk cycles after the frame_end cycle (cycle 0 sample, cycle 1 sum, cycle 2 output).
REQ-023 SHALL hold out_xy stable while out_valid=1 and out_ready=0, except when a new result arrives, which SHALL overwrite out_xy (latest wins) with out_valid staying 1.
REQ-024 SHALL clear out_valid the cycle after out_valid=1 and out_ready=1, unless a new result loads on that same edge, in which case out_valid stays 1 with the new out_xy.
REQ-025 SHALL use out_xy (last output, even if consumed) as the jump-gate reference in TRACK and COAST.
REQ-026 SHALL accept a frame_end pulse every cycle without loss (pipeline fully throughput-1).
REQ-027 SHALL treat laser_found=1 with laser_xy=0 as an ordinary sample.

Reset
REQ-028 SHALL, on reset_n low, immediately and asynchronously force state=ACQUIRE, out_xy=0, out_valid=0, tracking=0, sums, window, fill and miss counts =0, including mid-pipeline; in-flight samples discarded.
REQ-029 SHALL resume sampling on the first frame_end after reset_n deasserts.

Verification
REQ-030 Fill: 4 frames found at (100,50),(102,50),(104,52),(106,52) -> after 4th, tracking=1, out_valid=1 two cycles later, out_xy={103,51}.
REQ-031 Jump reject: tracking at (103,51), frame found at (300,51) -> miss, state COAST, no new out_valid, out_xy unchanged.
REQ-032 Loss: 8 consecutive frames laser_found=0 from TRACK -> after 8th, tracking=0, state ACQUIRE; next 3 hits produce no output, 4th does.
REQ-033 Backpressure: out_ready=0, two successive results {103,51} then {105,52} -> out_valid stays 1, out_xy={105,52}; out_ready=1 one cycle -> out_valid=0 next cycle; out_ready=1 same cycle as new result -> out_valid stays 1.
REQ-034 Async reset: assert reset_n low between frame_end and output cycle while tracking -> outputs zero immediately without waiting for clk; no out_valid after release until 4 new hits.

Source files
------------

// File: rtl/laser_xy_tracker_if.sv
// Frame-sample input and smoothed-position output bundle for laser_xy_tracker.
// The slave modport is the tracker; the master drives frames and consumes results.
interface laser_xy_tracker_if;
    logic        frame_end;
    logic        laser_found;
    logic [31:0] laser_xy;
    logic [31:0] out_xy;
    logic        out_valid;
    logic        out_ready;
    logic        tracking;

    modport master (
        output frame_end, laser_found, laser_xy, out_ready,
        input  out_xy, out_valid, tracking
    );

    modport slave (
        input  frame_end, laser_found, laser_xy, out_ready,
        output out_xy, out_valid, tracking
    );
endinterface

// File: rtl/laser_xy_tracker.sv
// Laser spot tracker: per-axis sliding-window average over accepted samples, with
// jump gating against the last output and coasting through short dropouts.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_ACQUIRE | filling an empty window; any found sample is accepted
// ST_TRACK   | window full, last frame was a hit; results are produced
// ST_COAST   | window full, one or more recent misses; drops after LOST_FRAMES
module laser_xy_tracker #(
    parameter int AVG_LOG2    = 2,
    parameter int MAX_JUMP    = 64,
    parameter int LOST_FRAMES = 8
) (
    input logic               clk,
    input logic               reset_n,
    laser_xy_tracker_if.slave bus
);
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = 16 + AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);

    localparam logic [15:0]       JUMP_LIM   = 16'(MAX_JUMP);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [AVG_LOG2:0] FILL_FULL  = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOST_FRAMES);

    typedef enum logic [1:0] {ST_ACQUIRE, ST_TRACK, ST_COAST} state_t;

    state_t            state_q, state_d;
    logic [15:0]       win_x_q [DEPTH];
    logic [15:0]       win_x_d [DEPTH];
    logic [15:0]       win_y_q [DEPTH];
    logic [15:0]       win_y_d [DEPTH];
    logic [SUM_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [AVG_LOG2:0] fill_q, fill_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              res_q, res_d;
    logic [31:0]       out_xy_q, out_xy_d;
    logic              out_valid_q, out_valid_d;

    logic [15:0] smp_x, smp_y, ref_x, ref_y, dist_x, dist_y;
    logic        near, hit, miss_ev, clr;

    assign smp_x   = bus.laser_xy[31:16];
    assign smp_y   = bus.laser_xy[15:0];
    assign ref_x   = out_xy_q[31:16];
    assign ref_y   = out_xy_q[15:0];
    assign dist_x  = (smp_x >= ref_x) ? (smp_x - ref_x) : (ref_x - smp_x);
    assign dist_y  = (smp_y >= ref_y) ? (smp_y - ref_y) : (ref_y - smp_y);
    assign near    = (dist_x <= JUMP_LIM) && (dist_y <= JUMP_LIM);
    assign hit     = bus.frame_end && bus.laser_found && ((state_q == ST_ACQUIRE) || near);
    assign miss_ev = bus.frame_end && !hit;

    always_comb begin
        state_d     = state_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        sum_x_d     = sum_x_q;
        sum_y_d     = sum_y_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        miss_d      = miss_q;
        res_d       = 1'b0;
        out_xy_d    = out_xy_q;
        out_valid_d = out_valid_q;
        clr         = 1'b0;

        // A freshly computed average outranks a same-cycle consume.
        if (res_q) begin
            out_xy_d    = {16'(sum_x_q >> AVG_LOG2), 16'(sum_y_q >> AVG_LOG2)};
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Unfilled slots hold zero, so subtracting the overwritten slot is always exact.
        if (hit) begin
            win_x_d[ptr_q] = smp_x;
            win_y_d[ptr_q] = smp_y;
            sum_x_d        = sum_x_q + SUM_W'(smp_x) - SUM_W'(win_x_q[ptr_q]);
            sum_y_d        = sum_y_q + SUM_W'(smp_y) - SUM_W'(win_y_q[ptr_q]);
            ptr_d          = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end

        unique case (state_q)
            ST_ACQUIRE: begin
                if (hit) begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q + 1'b1 == FILL_FULL) begin
                        state_d = ST_TRACK;
                        res_d   = 1'b1;
                    end
                end else if (miss_ev) begin
                    clr = 1'b1;
                end
            end
            ST_TRACK: begin
                if (hit) begin
                    res_d = 1'b1;
                end else if (miss_ev) begin
                    state_d = ST_COAST;
                    miss_d  = MISS_W'(1);
                end
            end
            ST_COAST: begin
                if (hit) begin
                    state_d = ST_TRACK;
                    miss_d  = '0;
                    res_d   = 1'b1;
                end else if (miss_ev) begin
                    if (miss_q + 1'b1 == MISS_LIMIT) begin
                        state_d = ST_ACQUIRE;
                        clr     = 1'b1;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
                clr     = 1'b1;
            end
        endcase

        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_x_d[i] = '0;
                win_y_d[i] = '0;
            end
            sum_x_d = '0;
            sum_y_d = '0;
            ptr_d   = '0;
            fill_d  = '0;
            miss_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ACQUIRE;
            for (int i = 0; i < DEPTH; i++) begin
                win_x_q[i] <= '0;
                win_y_q[i] <= '0;
            end
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            ptr_q       <= '0;
            fill_q      <= '0;
            miss_q      <= '0;
            res_q       <= 1'b0;
            out_xy_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            miss_q      <= miss_d;
            res_q       <= res_d;
            out_xy_q    <= out_xy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_xy    = out_xy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.tracking  = (state_q != ST_ACQUIRE);
endmodule
